// File: rtl/branch_seq.sv
// branch_seq: multi-cycle sequencer for Jcc/JCXZ/LOOPx with CX write-back and fetch redirect.
// Optional saturating outcome counters enabled by BRANCH_SEQ_STATS_EN.
module branch_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [3:0]  cond,
  input  logic        is_cx,
  input  logic [4:0]  logic_flags,
  input  logic [15:0] cx_in,
  input  logic [15:0] ip_next,
  input  logic [15:0] disp,
  output logic [15:0] cx_out,
  output logic        cx_we,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [15:0] redir_ip,
  output logic        done,
  output logic        taken
`ifdef BRANCH_SEQ_STATS_EN
  ,
  output logic [15:0] stat_taken,
  output logic [15:0] stat_total
`endif
);
  typedef enum logic [1:0] {IDLE, DEC, EVAL, REDIR} state_t;
  state_t state_q, state_d;
  logic [3:0] cond_q, cond_d;
  logic is_cx_q, is_cx_d;
  logic [4:0] flags_q, flags_d;
  logic [15:0] cx_l_q, cx_l_d, ip_l_q, ip_l_d, disp_l_q, disp_l_d;
  logic [15:0] cx_out_q, cx_out_d, redir_ip_q, redir_ip_d;
  logic ready_q, ready_d, cx_we_q, cx_we_d, redir_valid_q, redir_valid_d;
  logic done_q, done_d, taken_q, taken_d;
  logic of_f, sf_f, zf_f, pf_f, cf_f, cx_nz, jmp;
  logic [7:0] jcc_base;
  assign {of_f, sf_f, zf_f, pf_f, cf_f} = flags_q;
  // Jcc base condition indexed by cond[3:1]; cond[0] inverts it
  assign jcc_base = {zf_f | (sf_f ^ of_f), sf_f ^ of_f, pf_f, sf_f, cf_f | zf_f, zf_f, cf_f, of_f};
  assign cx_nz = cx_l_q != 16'h0000;
  assign jmp = !is_cx_q ? jcc_base[cond_q[3:1]] ^ cond_q[0] :
               cond_q == 4'h0 ? !cx_nz :
               cond_q == 4'h1 ? cx_nz :
               cond_q == 4'h2 ? zf_f & cx_nz : !zf_f & cx_nz;
  always_comb begin
    state_d = state_q;
    cond_d = cond_q;
    is_cx_d = is_cx_q;
    flags_d = flags_q;
    cx_l_d = cx_l_q;
    ip_l_d = ip_l_q;
    disp_l_d = disp_l_q;
    cx_out_d = cx_out_q;
    redir_ip_d = redir_ip_q;
    cx_we_d = 1'b0;
    done_d = 1'b0;
    taken_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cond_d = cond;
        is_cx_d = is_cx;
        flags_d = logic_flags;
        cx_l_d = cx_in;
        ip_l_d = ip_next;
        disp_l_d = disp;
        state_d = (is_cx && cond != 4'h0) ? DEC : EVAL;
        cx_we_d = is_cx && cond != 4'h0;
        cx_out_d = cx_we_d ? cx_in - 16'd1 : cx_out_q;
      end
      DEC: begin
        cx_l_d = cx_l_q - 16'd1;
        state_d = EVAL;
      end
      EVAL: begin
        redir_ip_d = jmp ? ip_l_q + disp_l_q : redir_ip_q;
        state_d = jmp ? REDIR : IDLE;
        done_d = !jmp;
      end
      REDIR: if (redir_ready) begin
        done_d = 1'b1;
        taken_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    redir_valid_d = state_d == REDIR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cond_q <= '0;
      is_cx_q <= 1'b0;
      flags_q <= '0;
      cx_l_q <= '0;
      ip_l_q <= '0;
      disp_l_q <= '0;
      cx_out_q <= '0;
      redir_ip_q <= '0;
      ready_q <= 1'b1;
      cx_we_q <= 1'b0;
      redir_valid_q <= 1'b0;
      done_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q <= cond_d;
      is_cx_q <= is_cx_d;
      flags_q <= flags_d;
      cx_l_q <= cx_l_d;
      ip_l_q <= ip_l_d;
      disp_l_q <= disp_l_d;
      cx_out_q <= cx_out_d;
      redir_ip_q <= redir_ip_d;
      ready_q <= ready_d;
      cx_we_q <= cx_we_d;
      redir_valid_q <= redir_valid_d;
      done_q <= done_d;
      taken_q <= taken_d;
    end
  end
  assign ready = ready_q;
  assign cx_out = cx_out_q;
  assign cx_we = cx_we_q;
  assign redir_valid = redir_valid_q;
  assign redir_ip = redir_ip_q;
  assign done = done_q;
  assign taken = taken_q;
`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] stat_taken_q, stat_taken_d, stat_total_q, stat_total_d;
  always_comb begin
    stat_total_d = stat_total_q + 16'(done_q && stat_total_q != 16'hffff);
    stat_taken_d = stat_taken_q + 16'(done_q && taken_q && stat_taken_q != 16'hffff);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_taken_q <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_taken_q <= stat_taken_d;
    end
  end
  assign stat_total = stat_total_q;
  assign stat_taken = stat_taken_q;
`endif
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: vector table, hand sequences and randomized model checks for branch_seq.
module tb_branch_seq;
  logic clk = 0, rst = 1, start = 0, is_cx = 0, redir_ready = 0;
  logic [3:0] cond = 0;
  logic [4:0] logic_flags = 0;
  logic [15:0] cx_in = 0, ip_next = 0, disp = 0;
  logic ready, cx_we, redir_valid, done, taken;
  logic [15:0] cx_out, redir_ip;
`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] stat_taken, stat_total;
`endif
  int checks = 0, errors = 0;

  branch_seq dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .cond(cond), .is_cx(is_cx),
    .logic_flags(logic_flags), .cx_in(cx_in), .ip_next(ip_next), .disp(disp),
    .cx_out(cx_out), .cx_we(cx_we), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_ip(redir_ip), .done(done), .taken(taken)
`ifdef BRANCH_SEQ_STATS_EN
    , .stat_taken(stat_taken), .stat_total(stat_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ic; logic [3:0] cd; logic [4:0] fl; logic [15:0] cx, ip, ds;
    int wt; logic tk; logic [15:0] cxo, rip;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference outcome from the architectural branch rules; flags = {OF,SF,ZF,PF,CF}
  function automatic logic model_taken(logic ic, logic [3:0] cd, logic [4:0] fl, logic [15:0] cx);
    logic o, s, z, p, c, b;
    int dec;
    {o, s, z, p, c} = fl;
    if (!ic) begin
      case (cd[3:1])
        3'd0: b = o;
        3'd1: b = c;
        3'd2: b = z;
        3'd3: b = c | z;
        3'd4: b = s;
        3'd5: b = p;
        3'd6: b = s ^ o;
        default: b = z | (s ^ o);
      endcase
      return b ^ cd[0];
    end
    if (cd == 0) return cx == 0;
    dec = (int'(cx) + 65535) % 65536;
    if (cd == 1) return dec != 0;
    if (cd == 2) return z && dec != 0;
    return !z && dec != 0;
  endfunction

  // Issue one request and watch it to completion; called and returns at #1 after a posedge
  task automatic do_req(input logic ic, input logic [3:0] cd, input logic [4:0] fl,
                        input logic [15:0] cx, input logic [15:0] ip, input logic [15:0] ds,
                        input int wt, input logic exp_tk, input logic [15:0] exp_cx,
                        input logic [15:0] exp_ip);
    int t_we, t_rv, t_done, n_rv, n_we, lp, w;
    logic tk;
    logic [15:0] cxo;
    lp = (ic && cd != 0) ? 1 : 0;
    w = 0;
    while (!ready && w < 50) begin tick(); w++; end
    chk("ready_before_start", ready, 1);
    is_cx = ic; cond = cd; logic_flags = fl; cx_in = cx; ip_next = ip; disp = ds;
    start = 1;
    redir_ready = (wt == 0);
    tick();
    start = 0;
    logic_flags = 5'($urandom); cx_in = 16'($urandom); ip_next = 16'($urandom); disp = 16'($urandom);
    cond = 4'($urandom); is_cx = 1'($urandom);
    t_we = -1; t_rv = -1; t_done = -1; n_rv = 0; n_we = 0; tk = 0; cxo = 0;
    for (int t = 1; t <= 40 && t_done < 0; t++) begin
      if (t == 1) chk("ready_low", ready, 0);
      if (cx_we) begin n_we++; t_we = t; cxo = cx_out; end
      if (redir_valid) begin
        n_rv++;
        if (t_rv < 0) t_rv = t;
        chk("redir_ip", redir_ip, exp_ip);
      end
      redir_ready = n_rv > wt;
      start = redir_valid && n_rv == 2 && n_rv <= wt;
      if (done) begin
        t_done = t;
        tk = taken;
        chk("ready_at_done", ready, 1);
        chk("valid_at_done", redir_valid, 0);
      end else tick();
    end
    start = 0;
    if (t_done < 0) begin
      checks++; errors++;
      $display("FAIL timeout: got no done expected done");
    end else begin
      chk("done_cycle", t_done, 2 + lp + (exp_tk ? 1 + wt : 0));
      chk("taken", tk, exp_tk);
      chk("cx_we_count", n_we, lp);
      if (lp != 0) begin
        chk("cx_we_cycle", t_we, 1);
        chk("cx_out", cxo, exp_cx);
      end
      chk("redir_cycles", n_rv, exp_tk ? wt + 1 : 0);
      if (exp_tk) chk("redir_start", t_rv, 2 + lp);
    end
    redir_ready = 0;
    tick();
    chk("idle_after_done", {ready, done, cx_we, redir_valid}, 4'b1000);
  endtask

  vec_t v[10];

  initial begin
    v[0] = '{0, 4'h4, 5'b00100, 16'h0000, 16'h0100, 16'hfff0, 0, 1, 16'h0000, 16'h00f0};
    v[1] = '{0, 4'he, 5'b10000, 16'h0000, 16'h1234, 16'h0010, 0, 1, 16'h0000, 16'h1244};
    v[2] = '{0, 4'he, 5'b00000, 16'h0000, 16'h1234, 16'h0010, 0, 0, 16'h0000, 16'h0000};
    v[3] = '{1, 4'h1, 5'b00000, 16'h0001, 16'h0200, 16'h0004, 0, 0, 16'h0000, 16'h0000};
    v[4] = '{1, 4'h1, 5'b00000, 16'h0000, 16'h0200, 16'h0004, 0, 1, 16'hffff, 16'h0204};
    v[5] = '{1, 4'h0, 5'b00000, 16'h0000, 16'h0300, 16'h0002, 0, 1, 16'h0000, 16'h0302};
    v[6] = '{1, 4'h3, 5'b00100, 16'h0005, 16'h0400, 16'h0002, 0, 0, 16'h0004, 16'h0000};
    v[7] = '{0, 4'h4, 5'b00100, 16'h0000, 16'h0010, 16'h0020, 5, 1, 16'h0000, 16'h0030};
    v[8] = '{0, 4'h5, 5'b00100, 16'h0000, 16'h0010, 16'h0020, 0, 0, 16'h0000, 16'h0000};
    v[9] = '{1, 4'h2, 5'b00100, 16'h0003, 16'hffff, 16'h0002, 2, 1, 16'h0002, 16'h0001};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ready, cx_we, redir_valid, done, taken}, 5'b10000);
    chk("reset_cx_out", cx_out, 0);
    chk("reset_redir_ip", redir_ip, 0);
    rst = 0;
    tick();
    for (int i = 0; i < 10; i++)
      do_req(v[i].ic, v[i].cd, v[i].fl, v[i].cx, v[i].ip, v[i].ds, v[i].wt, v[i].tk, v[i].cxo, v[i].rip);

    // Reset while a redirect is pending drops it without a done
    is_cx = 0; cond = 4'h4; logic_flags = 5'b00100; ip_next = 16'h1000; disp = 16'h0100;
    start = 1; redir_ready = 0;
    tick();
    start = 0;
    for (int w = 0; w < 20 && !redir_valid; w++) tick();
    chk("pre_reset_valid", redir_valid, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_reset_state", {ready, redir_valid, done, cx_we}, 4'b1000);
    for (int w = 0; w < 4; w++) begin
      chk("no_done_after_reset", done, 0);
      tick();
    end
    do_req(1, 4'h1, 5'b00000, 16'h0002, 16'h0050, 16'h0005, 1, 1, 16'h0001, 16'h0055);

    // Reset wins over a simultaneous start
    is_cx = 0; cond = 4'h5; logic_flags = 0; start = 1; rst = 1;
    tick();
    start = 0; rst = 0;
    chk("rst_over_start", {ready, done, redir_valid}, 3'b100);
    tick();
    chk("rst_over_start_idle", {ready, done, redir_valid}, 3'b100);

    for (int i = 0; i < 40; i++) begin
      logic ic, tk;
      logic [3:0] cd;
      logic [4:0] fl;
      logic [15:0] cx, ip, ds;
      int wt;
      ic = 1'($urandom); cd = 4'($urandom); fl = 5'($urandom);
      cx = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      ip = 16'($urandom); ds = 16'($urandom); wt = $urandom_range(0, 3);
      tk = model_taken(ic, cd, fl, cx);
      do_req(ic, cd, fl, cx, ip, ds, wt, tk, 16'((int'(cx) + 65535) % 65536),
             16'((int'(ip) + int'(ds)) % 65536));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Multi-cycle sequencer for conditional control transfers: Jcc, JCXZ, LOOP, LOOPZ and LOOPNZ.
- Accepts one branch request from the decode/exec stage and latches its operands.
- For LOOP-class requests, performs the CX decrement and issues the CX write-back.
- Evaluates the branch condition, then either hands a redirect target to the fetch unit over a valid/ready handshake or retires the request as not-taken.

Parameters:
- none (widths fixed by the 16-bit architecture)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request valid; accepted only when ready=1
- ready  out  1  high when idle and able to accept a request
- cond  in  4  condition code (opcode low nibble, or loop subtype)
- is_cx  in  1  1 = CX-class instruction (JCXZ/LOOPx)
- logic_flags  in  5  {OF,SF,ZF,PF,CF}
- cx_in  in  16  current CX value
- ip_next  in  16  IP of the following instruction
- disp  in  16  sign-extended displacement
- cx_out  out  16  decremented CX
- cx_we  out  1  one-cycle CX write strobe
- redir_valid  out  1  redirect target valid
- redir_ready  in  1  fetch unit accepts the redirect
- redir_ip  out  16  branch target
- done  out  1  one-cycle completion pulse
- taken  out  1  outcome, valid while done=1

Behaviour:
- Reset values: state IDLE; all latches 0; ready=1; cx_we, redir_valid, done, taken, cx_out and redir_ip all 0.
- All outputs are registered.
- States are IDLE, DEC, EVAL, REDIR.
- IDLE:
  - start=1 latches cond, is_cx, flags, cx_in, ip_next and disp; ready drops the next cycle.
  - Next state is DEC if is_cx=1 and cond!=0000, otherwise EVAL.
- DEC (1 cycle):
  - cx_l <= cx_l-1, modulo 2^16 (0000 wraps to FFFF).
  - cx_out = new value and cx_we=1 for exactly this cycle.
  - Next state is EVAL.
- EVAL (1 cycle): compute jmp.
  - is_cx=0: base is selected by cond[3:1]: 000 OF, 001 CF, 010 ZF, 011 CF|ZF, 100 SF, 101 PF, 110 SF^OF, 111 ZF|(SF^OF). jmp = base ^ cond[0].
  - is_cx=1, cond=0000 (JCXZ): jmp = (latched CX == 0); no decrement.
  - is_cx=1, cond=0001 (LOOP): jmp = (CX_dec != 0).
  - is_cx=1, cond=0010 (LOOPZ): jmp = ZF & (CX_dec != 0).
  - is_cx=1, any other cond: treated as LOOPNZ, jmp = ~ZF & (CX_dec != 0).
  - Flags used are those latched at acceptance; changes on logic_flags after acceptance are ignored.
  - jmp=1: redir_ip <= ip_l + disp_l (mod 2^16); go to REDIR.
  - jmp=0: done=1, taken=0 on the next cycle; return to IDLE.
- REDIR:
  - redir_valid=1; redir_ip stays stable until redir_ready=1 is sampled.
  - On handshake: redir_valid drops, done=1 and taken=1 the next cycle, return to IDLE.
  - redir_ready may be asserted in the first REDIR cycle (zero-wait completion).
- Latency, with request accepted at cycle N:
  - Jcc/JCXZ not-taken: done at N+2.
  - Taken: redir_valid from N+2.
  - LOOP-class adds 1 cycle (cx_we at N+1).
- ready returns to 1 in the same cycle done is high; a new start may be accepted in that cycle.
- start while ready=0 is ignored (no queuing).
- Reset mid-operation: next edge returns to IDLE and clears all outputs; the in-flight request is dropped with no done. A pending redirect is withdrawn.
- rst has priority over start in the same cycle.

Optional Feature:
- Macro BRANCH_SEQ_STATS_EN.
- Defined:
  - Adds outputs stat_taken[15:0] and stat_total[15:0].
  - stat_total increments on every done pulse; stat_taken increments on done with taken=1.
  - Both saturate at FFFF and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- JZ (cond=0100, is_cx=0), ZF=1, ip_next=0100, disp=FFF0, redir_ready=1 -> redir_valid at N+2 with redir_ip=00F0; done with taken=1 at N+3; cx_we never asserted.
- JLE (cond=1110), flags OF=1 SF=0 ZF=0 -> taken. Same request with OF=0 SF=0 ZF=0 -> done at N+2 with taken=0.
- LOOP (is_cx=1, cond=0001):
  - cx_in=0001 -> cx_we at N+1 with cx_out=0000; not taken.
  - cx_in=0000 -> cx_out=FFFF; taken.
- JCXZ (cond=0000), cx_in=0000 -> no cx_we; taken. LOOPNZ (cond=0011), cx_in=0005, ZF=1 -> cx_out=0004; not taken.
- Redirect backpressure: hold redir_ready=0 for 5 cycles -> redir_valid and redir_ip stable throughout; a start pulse during this wait is ignored; done is asserted one cycle after redir_ready rises.
- Reset mid-operation: assert rst while in REDIR -> next cycle ready=1 and redir_valid=0, with no done. A subsequent request then completes normally.
